// File: rtl/hamster_pkg.sv
// Shared types and default constants for the whack-a-mole pulse-to-level stage.
// Optional feature macro: HAMSTER_SPEEDUP_EN (adds a level input that shortens pop-up time).
package hamster_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      COOL = 2'd2
   } hole_state_t;

   localparam int unsigned N_HOLES_DEF    = 10;
   localparam int unsigned PRESCALE_DEF   = 100000;
   localparam int unsigned UP_TICKS_DEF   = 1500;
   localparam int unsigned COOL_TICKS_DEF = 200;

   function automatic int unsigned umax(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hamster_hole_fsm.sv
// One hole: IDLE/UP/COOL state with a tick down-counter and registered LED and event pulses.
module hamster_hole_fsm
   import hamster_pkg::*;
#(
   parameter int unsigned CW         = 8,
   parameter int unsigned COOL_TICKS = COOL_TICKS_DEF
) (
   input  logic          clk_100,
   input  logic          rst,
   input  logic          game_en,
   input  logic          tick,
   input  logic          spawn,
   input  logic          hit,
   input  logic [CW-1:0] load_val,
   output logic          led,
   output logic          hit_ev,
   output logic          miss_ev,
   output logic          wrong_ev,
   output logic          active
);

   hole_state_t   state;
   logic [CW-1:0] cnt;

   // A tick arriving in the same cycle as a spawn or a hit is absorbed by the reload.
   always_ff @(posedge clk_100) begin
      if (rst || !game_en) begin
         state    <= IDLE;
         cnt      <= '0;
         led      <= 1'b0;
         hit_ev   <= 1'b0;
         miss_ev  <= 1'b0;
         wrong_ev <= 1'b0;
         active   <= 1'b0;
      end else begin
         hit_ev   <= 1'b0;
         miss_ev  <= 1'b0;
         wrong_ev <= 1'b0;
         case (state)
            IDLE: begin
               if (spawn) begin
                  state  <= UP;
                  cnt    <= load_val;
                  led    <= 1'b1;
                  active <= 1'b1;
               end else if (hit) begin
                  wrong_ev <= 1'b1;
               end
            end
            UP: begin
               if (hit) begin
                  state  <= COOL;
                  cnt    <= CW'(COOL_TICKS);
                  led    <= 1'b0;
                  hit_ev <= 1'b1;
               end else if (tick) begin
                  if (cnt <= CW'(1)) begin
                     state   <= COOL;
                     cnt     <= CW'(COOL_TICKS);
                     led     <= 1'b0;
                     miss_ev <= 1'b1;
                  end else begin
                     cnt <= cnt - CW'(1);
                  end
               end
            end
            COOL: begin
               if (hit) begin
                  wrong_ev <= 1'b1;
               end
               if (tick) begin
                  if (cnt <= CW'(1)) begin
                     state  <= IDLE;
                     cnt    <= '0;
                     active <= 1'b0;
                  end else begin
                     cnt <= cnt - CW'(1);
                  end
               end
            end
            default: begin
               state  <= IDLE;
               cnt    <= '0;
               led    <= 1'b0;
               active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/hamster_led_hold.sv
// Spawn/whack pulses to held LED levels and per-hole hit/miss/wrong events.
// Optional feature macro: HAMSTER_SPEEDUP_EN (adds level[1:0], pop-up load = max(UP_TICKS >> level, 1)).
module hamster_led_hold
   import hamster_pkg::*;
#(
   parameter int unsigned N_HOLES    = N_HOLES_DEF,
   parameter int unsigned PRESCALE   = PRESCALE_DEF,
   parameter int unsigned UP_TICKS   = UP_TICKS_DEF,
   parameter int unsigned COOL_TICKS = COOL_TICKS_DEF
) (
   input  logic               clk_100,
   input  logic               rst,
   input  logic               game_en,
   input  logic [N_HOLES-1:0] spawn_pulse,
   input  logic [N_HOLES-1:0] hit_pulse,
`ifdef HAMSTER_SPEEDUP_EN
   input  logic [1:0]         level,
`endif
   output logic [N_HOLES-1:0] led_cont,
   output logic [N_HOLES-1:0] hit_vec,
   output logic [N_HOLES-1:0] miss_vec,
   output logic [N_HOLES-1:0] wrong_vec,
   output logic               busy
);

   localparam int unsigned TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned CW = $clog2(umax(UP_TICKS, COOL_TICKS) + 1);

   logic [TW-1:0]      pre_cnt;
   logic               tick;
   logic [CW-1:0]      load_val;
   logic [N_HOLES-1:0] hole_active;

   // Game-tick prescaler; free-running regardless of game_en.
   always_ff @(posedge clk_100) begin
      if (rst) begin
         pre_cnt <= '0;
      end else if (pre_cnt == TW'(PRESCALE - 1)) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + TW'(1);
      end
   end

   assign tick = (pre_cnt == TW'(PRESCALE - 1));

`ifdef HAMSTER_SPEEDUP_EN
   // Higher levels shorten the pop-up, never below one tick.
   always_comb begin
      load_val = CW'(UP_TICKS >> level);
      if (load_val == '0) begin
         load_val = CW'(1);
      end
   end
`else
   assign load_val = CW'(UP_TICKS);
`endif

   for (genvar i = 0; i < N_HOLES; i++) begin : g_hole
      hamster_hole_fsm #(
         .CW         (CW),
         .COOL_TICKS (COOL_TICKS)
      ) u_hole (
         .clk_100  (clk_100),
         .rst      (rst),
         .game_en  (game_en),
         .tick     (tick),
         .spawn    (spawn_pulse[i]),
         .hit      (hit_pulse[i]),
         .load_val (load_val),
         .led      (led_cont[i]),
         .hit_ev   (hit_vec[i]),
         .miss_ev  (miss_vec[i]),
         .wrong_ev (wrong_vec[i]),
         .active   (hole_active[i])
      );
   end

   // OR of per-hole registered activity flags.
   assign busy = |hole_active;

endmodule
